// File: rtl/button_conditioner.sv
// button_conditioner: per-channel 2-flop synchroniser followed by a debounce FSM.
// Produces a registered clean level and one-cycle press/release pulses per button.
module button_conditioner #(
  parameter int NBTN            = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic            CLK,
  input  logic            clear,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release
);

  // state | meaning
  // REL   | released and stable
  // W_PRS | synced input high, counting towards a debounced press
  // PRS   | pressed and stable
  // W_REL | synced input low, counting towards a debounced release
  typedef enum logic [1:0] {
    REL   = 2'd0,
    W_PRS = 2'd1,
    PRS   = 2'd2,
    W_REL = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NBTN-1:0] r_sync1;
  logic [NBTN-1:0] r_sync2;

  always_ff @(posedge CLK or posedge clear) begin
    if (clear) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NBTN; gi++) begin : g_ch
      state_t           r_state;
      state_t           w_state_nxt;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_nxt;
      logic             r_level;
      logic             r_press;
      logic             r_release;
      logic             w_level_nxt;
      logic             w_press_nxt;
      logic             w_release_nxt;
      logic             w_s;

      assign w_s = r_sync2[gi];

      always_ff @(posedge CLK or posedge clear) begin
        if (clear) begin
          r_state   <= REL;
          r_cnt     <= '0;
          r_level   <= 1'b0;
          r_press   <= 1'b0;
          r_release <= 1'b0;
        end else begin
          r_state   <= w_state_nxt;
          r_cnt     <= w_cnt_nxt;
          r_level   <= w_level_nxt;
          r_press   <= w_press_nxt;
          r_release <= w_release_nxt;
        end
      end

      // The counter always exits at CNT_LAST, so it can never wrap.
      always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
          REL: begin
            if (w_s) begin
              w_state_nxt = W_PRS;
              w_cnt_nxt   = '0;
            end
          end
          W_PRS: begin
            if (!w_s)                  w_state_nxt = REL;
            else if (r_cnt == CNT_LAST) w_state_nxt = PRS;
            else                        w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
          PRS: begin
            if (!w_s) begin
              w_state_nxt = W_REL;
              w_cnt_nxt   = '0;
            end
          end
          W_REL: begin
            if (w_s)                    w_state_nxt = PRS;
            else if (r_cnt == CNT_LAST) w_state_nxt = REL;
            else                        w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
          default: begin
            w_state_nxt = REL;
            w_cnt_nxt   = '0;
          end
        endcase
      end

      always_comb begin
        w_level_nxt   = (w_state_nxt == PRS) || (w_state_nxt == W_REL);
        w_press_nxt   = (r_state == W_PRS) && (w_state_nxt == PRS);
        w_release_nxt = (r_state == W_REL) && (w_state_nxt == REL);
      end

      assign btn_level[gi]   = r_level;
      assign btn_press[gi]   = r_press;
      assign btn_release[gi] = r_release;
    end
  endgenerate

endmodule
